// File: rtl/ls_mem_responder.sv
// rtl/ls_mem_responder.sv - two-core load/store responder onto one single-port synchronous RAM
module ls_mem_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req0,
    input  logic [ADDR_W-1:0] rd_adrs0,
    input  logic              wr_req0,
    input  logic [ADDR_W-1:0] wr_adrs0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              rd_req1,
    input  logic [ADDR_W-1:0] rd_adrs1,
    input  logic              wr_req1,
    input  logic [ADDR_W-1:0] wr_adrs1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              rd_valid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              wr_valid0,
    output logic              rd_valid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              wr_valid1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [1:0]       state;
    logic             last_port;
    logic             sel_port;
    logic             sel_we;
    logic [CNT_W-1:0] cnt;

    logic              elig_wr0, elig_rd0, elig_wr1, elig_rd1;
    logic              any0, any1;
    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_adrs;
    logic [DATA_W-1:0] pick_wdata;
    logic              done_wr, done_rd;

    // A request that already has its valid raised is waiting for the core to drop req.
    always_comb begin
        elig_wr0   = wr_req0 & ~wr_valid0;
        elig_rd0   = rd_req0 & ~rd_valid0;
        elig_wr1   = wr_req1 & ~wr_valid1;
        elig_rd1   = rd_req1 & ~rd_valid1;
        any0       = elig_wr0 | elig_rd0;
        any1       = elig_wr1 | elig_rd1;
        pick       = (any0 & any1) ? ~last_port : any1;
        pick_we    = pick ? elig_wr1 : elig_wr0;
        pick_wdata = pick ? wdata1 : wdata0;
        if (pick) begin
            pick_adrs = elig_wr1 ? wr_adrs1 : rd_adrs1;
        end else begin
            pick_adrs = elig_wr0 ? wr_adrs0 : rd_adrs0;
        end
    end

    // Strobe decoded from state so an asynchronous reset drops it immediately.
    assign mem_en  = (state == S_ISSUE);
    assign mem_we  = mem_en & sel_we;
    assign done_wr = (state == S_ISSUE) & sel_we;
    assign done_rd = (state == S_WAIT) & (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last_port <= 1'b1;
            sel_port  <= 1'b0;
            sel_we    <= 1'b0;
            cnt       <= '0;
            mem_adrs  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any0 | any1) begin
                        state     <= S_ISSUE;
                        sel_port  <= pick;
                        sel_we    <= pick_we;
                        last_port <= pick;
                        mem_adrs  <= pick_adrs;
                        if (pick_we) begin
                            mem_wdata <= pick_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (sel_we) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Completion wins over the req-low clear, so a dropped in-flight request still pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid0 <= 1'b0;
            wr_valid1 <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            wr_valid0 <= (done_wr & ~sel_port) | (wr_valid0 & wr_req0);
            wr_valid1 <= (done_wr &  sel_port) | (wr_valid1 & wr_req1);
            rd_valid0 <= (done_rd & ~sel_port) | (rd_valid0 & rd_req0);
            rd_valid1 <= (done_rd &  sel_port) | (rd_valid1 & rd_req1);
            if (done_rd & ~sel_port) begin
                rdata0 <= mem_rdata;
            end
            if (done_rd & sel_port) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ls_mem_responder.sv
// tb/tb_ls_mem_responder.sv - directed checks of ls_mem_responder against a RD_LAT=2 RAM model
module tb_ls_mem_responder;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic              rd_req0, wr_req0, rd_req1, wr_req1;
    logic [ADDR_W-1:0] rd_adrs0, wr_adrs0, rd_adrs1, wr_adrs1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              rd_valid0, wr_valid0, rd_valid1, wr_valid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_adrs;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_pipe;
    logic [ADDR_W:0]   issue_log [$];

    int vectors;
    int errors;

    ls_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req0   (rd_req0),
        .rd_adrs0  (rd_adrs0),
        .wr_req0   (wr_req0),
        .wr_adrs0  (wr_adrs0),
        .wdata0    (wdata0),
        .rd_req1   (rd_req1),
        .rd_adrs1  (rd_adrs1),
        .wr_req1   (wr_req1),
        .wr_adrs1  (wr_adrs1),
        .wdata1    (wdata1),
        .rd_valid0 (rd_valid0),
        .rdata0    (rdata0),
        .wr_valid0 (wr_valid0),
        .rd_valid1 (rd_valid1),
        .rdata1    (rdata1),
        .wr_valid1 (wr_valid1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_adrs  (mem_adrs),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage read pipeline: data appears RD_LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_adrs] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            ram_pipe <= ram[mem_adrs];
        end
        mem_rdata <= ram_pipe;
    end

    always @(negedge clk) begin
        if (mem_en) begin
            issue_log.push_back({mem_we, mem_adrs});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic valid_of(input int which);
        case (which)
            0:       return rd_valid0;
            1:       return rd_valid1;
            2:       return wr_valid0;
            default: return wr_valid1;
        endcase
    endfunction

    task automatic wait_valid(input int which, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (valid_of(which)) break;
            tick();
        end
        check(tag, 64'(valid_of(which)), 64'd1);
    endtask

    task automatic log_entry(input string tag, input int idx, input logic [ADDR_W:0] exp);
        logic [ADDR_W:0] got;
        got = (issue_log.size() > idx) ? issue_log[idx] : '1;
        check(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        rst      = 1'b1;
        rd_req0  = 0; wr_req0 = 0; rd_req1 = 0; wr_req1 = 0;
        rd_adrs0 = '0; wr_adrs0 = '0; rd_adrs1 = '0; wr_adrs1 = '0;
        wdata0   = '0; wdata1 = '0;
        ram_pipe = '0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        ram[11'h020] = 32'h12345678;
        ram[11'h100] = 32'h00000001;
        ram[11'h200] = 32'h00000002;
        ram[11'h050] = 32'hFFFF0000;

        @(negedge clk);
        tick();
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_valids", 64'({rd_valid0, wr_valid0, rd_valid1, wr_valid1}), 64'd0);
        check("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
        check("rst_adrs", 64'(mem_adrs), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single write on port 0, exact latency
        wr_req0 = 1; wr_adrs0 = 11'h010; wdata0 = 32'hDEADBEEF;
        tick();
        check("t1_en", 64'({mem_en, mem_we}), 64'h3);
        check("t1_adrs", 64'(mem_adrs), 64'h010);
        check("t1_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("t1_valid_c1", 64'(wr_valid0), 64'd0);
        tick();
        check("t1_valid_c2", 64'(wr_valid0), 64'd1);
        check("t1_en_off", 64'(mem_en), 64'd0);
        wr_req0 = 0;
        tick();
        check("t1_valid_clr", 64'(wr_valid0), 64'd0);
        check("t1_ram", 64'(ram[11'h010]), 64'hDEADBEEF);

        // 2: read on port 1, RD_LAT=2 -> valid from cycle 4
        rd_req1 = 1; rd_adrs1 = 11'h020;
        tick();
        check("t2_en", 64'({mem_en, mem_we}), 64'h2);
        check("t2_adrs", 64'(mem_adrs), 64'h020);
        tick();
        check("t2_valid_c2", 64'(rd_valid1), 64'd0);
        tick();
        check("t2_valid_c3", 64'(rd_valid1), 64'd0);
        tick();
        check("t2_valid_c4", 64'(rd_valid1), 64'd1);
        check("t2_rdata", 64'(rdata1), 64'h12345678);
        tick(); tick();
        check("t2_hold", 64'(rd_valid1), 64'd1);
        rd_req1 = 0;
        tick();
        check("t2_clr", 64'(rd_valid1), 64'd0);
        check("t2_rdata_hold", 64'(rdata1), 64'h12345678);

        // 3: round-robin after reset (last_port=1)
        rst = 1; tick(); rst = 0; tick();
        issue_log.delete();
        rd_req0 = 1; rd_adrs0 = 11'h100; rd_req1 = 1; rd_adrs1 = 11'h200;
        wait_valid(0, "t3_v0");
        wait_valid(1, "t3_v1");
        log_entry("t3_first", 0, 12'h100);
        log_entry("t3_second", 1, 12'h200);
        check("t3_rdata0", 64'(rdata0), 64'h1);
        check("t3_rdata1", 64'(rdata1), 64'h2);
        rd_req0 = 0; rd_req1 = 0;
        tick();
        check("t3_clr", 64'({rd_valid0, rd_valid1}), 64'd0);
        issue_log.delete();
        rd_req0 = 1; rd_req1 = 1;
        wait_valid(0, "t3b_v0");
        wait_valid(1, "t3b_v1");
        log_entry("t3b_first", 0, 12'h100);
        log_entry("t3b_second", 1, 12'h200);
        rd_req0 = 0; rd_req1 = 0;
        tick();

        // 4: write beats read on the same port
        issue_log.delete();
        wr_req0 = 1; rd_req0 = 1; wr_adrs0 = 11'h030; rd_adrs0 = 11'h030; wdata0 = 32'hA5A5A5A5;
        wait_valid(0, "t4_rv");
        log_entry("t4_first_wr", 0, 12'h830);
        log_entry("t4_then_rd", 1, 12'h030);
        check("t4_rdata", 64'(rdata0), 64'hA5A5A5A5);
        check("t4_wv", 64'(wr_valid0), 64'd1);
        wr_req0 = 0; rd_req0 = 0;
        tick();

        // 5: held request is served once
        issue_log.delete();
        rd_req0 = 1; rd_adrs0 = 11'h020;
        wait_valid(0, "t5_v");
        repeat (20) tick();
        check("t5_once", 64'(issue_log.size()), 64'd1);
        check("t5_still", 64'(rd_valid0), 64'd1);
        rd_req0 = 0;
        tick();
        check("t5_clr", 64'(rd_valid0), 64'd0);
        rd_req0 = 1;
        wait_valid(0, "t5_again");
        check("t5_twice", 64'(issue_log.size()), 64'd2);
        rd_req0 = 0;
        tick();

        // 6: reset during the write ISSUE cycle
        wr_req1 = 1; wr_adrs1 = 11'h050; wdata1 = 32'h11112222;
        tick();
        check("t6_issue", 64'({mem_en, mem_we}), 64'h3);
        rst = 1;
        #1;
        check("t6_en_async", 64'(mem_en), 64'd0);
        @(negedge clk);
        check("t6_no_valid", 64'(wr_valid1), 64'd0);
        check("t6_state", 64'(dut.state), 64'd0);
        check("t6_ram_untouched", 64'(ram[11'h050]), 64'hFFFF0000);
        issue_log.delete();
        rst = 0;
        wait_valid(3, "t6_reserved");
        log_entry("t6_log", 0, 12'h850);
        check("t6_ram", 64'(ram[11'h050]), 64'h11112222);
        wr_req1 = 0;
        tick();
        check("t6_clr", 64'(wr_valid1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
